// File: rtl/rv32i_types.sv
// Shared types for the cache-to-bmem arbiter: FSM encodings, line geometry,
// and the line-address alignment helper.
package rv32i_types;

  localparam int BEATS_PER_LINE = 4;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t IDLE     = 3'd0;
  localparam arb_state_t RD_ISSUE = 3'd1;
  localparam arb_state_t RD_WAIT  = 3'd2;
  localparam arb_state_t WR_BURST = 3'd3;
  localparam arb_state_t RESP     = 3'd4;

  // Lines are 32 bytes, so the low five address bits select within a line.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~32'h0000_001f;
  endfunction

endpackage

// File: rtl/line_assembler.sv
// Four-beat line register with a beat counter: fills beat by beat on reads,
// and presents the current beat for serialisation on writes.
module line_assembler
  import rv32i_types::*;
#(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [LINE_W-1:0] load_line_i,
  input  logic              capture_i,
  input  logic [BEAT_W-1:0] beat_i,
  input  logic              advance_i,
  output logic [LINE_W-1:0] line_o,
  output logic [BEAT_W-1:0] beat_o,
  output logic              last_o
);

  localparam int CNT_W = $clog2(BEATS_PER_LINE);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;

  // Load wins over capture/advance so a fresh grant always restarts at beat 0.
  always_comb begin
    cnt_d  = cnt_q;
    line_d = line_q;
    if (load_i) begin
      line_d = load_line_i;
      cnt_d  = '0;
    end else if (capture_i) begin
      line_d[int'(cnt_q)*BEAT_W +: BEAT_W] = beat_i;
      cnt_d = cnt_q + CNT_W'(1);
    end else if (advance_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end

  assign line_o = line_q;
  assign beat_o = line_q[int'(cnt_q)*BEAT_W +: BEAT_W];
  assign last_o = (cnt_q == CNT_W'(BEATS_PER_LINE - 1));

endmodule

// File: rtl/bmem_arbiter.sv
// Arbitrates icache/dcache line requests onto the single 64-bit burst memory
// port, one transaction at a time, with round-robin on ties.
module bmem_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [31:0]       d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  arb_state_t  state_q, state_d;
  logic        last_was_d_q, last_was_d_d;
  logic        owner_d_q, owner_d_d;
  logic        is_write_q, is_write_d;
  logic [31:0] addr_q, addr_d;

  logic              want_i, want_d, grant_any, grant_d, beat_match;
  logic              asm_load, asm_capture, asm_advance, asm_last;
  logic [LINE_W-1:0] asm_load_line, asm_line;
  logic [BEAT_W-1:0] asm_beat;

  assign want_i     = i_read;
  assign want_d     = d_read | d_write;
  assign grant_any  = want_i | want_d;
  // dcache takes a tie unless it won the previous grant.
  assign grant_d    = want_d && (!want_i || !last_was_d_q);
  assign beat_match = bmem_rvalid && (bmem_raddr == addr_q);

  assign asm_load_line = (grant_d && d_write) ? d_wdata : '0;

  always_comb begin
    state_d      = state_q;
    last_was_d_d = last_was_d_q;
    owner_d_d    = owner_d_q;
    is_write_d   = is_write_q;
    addr_d       = addr_q;
    asm_load     = 1'b0;
    asm_capture  = 1'b0;
    asm_advance  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          owner_d_d    = grant_d;
          last_was_d_d = grant_d;
          is_write_d   = grant_d && d_write;
          addr_d       = line_align(grant_d ? d_addr : i_addr);
          asm_load     = 1'b1;
          state_d      = (grant_d && d_write) ? WR_BURST : RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (bmem_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (beat_match) begin
          asm_capture = 1'b1;
          if (asm_last) state_d = RESP;
        end
      end
      WR_BURST: begin
        if (bmem_ready) begin
          asm_advance = 1'b1;
          if (asm_last) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_was_d_q <= 1'b0;
      owner_d_q    <= 1'b0;
      is_write_q   <= 1'b0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_was_d_q <= last_was_d_d;
      owner_d_q    <= owner_d_d;
      is_write_q   <= is_write_d;
      addr_q       <= addr_d;
    end
  end

  line_assembler #(
    .LINE_W(LINE_W),
    .BEAT_W(BEAT_W)
  ) u_line_assembler (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (asm_load),
    .load_line_i(asm_load_line),
    .capture_i  (asm_capture),
    .beat_i     (bmem_rdata),
    .advance_i  (asm_advance),
    .line_o     (asm_line),
    .beat_o     (asm_beat),
    .last_o     (asm_last)
  );

  assign bmem_read  = (state_q == RD_ISSUE);
  assign bmem_write = (state_q == WR_BURST);
  assign bmem_addr  = (bmem_read || bmem_write) ? addr_q : '0;
  assign bmem_wdata = bmem_write ? asm_beat : '0;

  assign i_resp  = (state_q == RESP) && !owner_d_q;
  assign d_resp  = (state_q == RESP) && owner_d_q;
  // Both read ports share one line register, gated so only the owner sees it.
  assign i_rdata = (i_resp && !is_write_q) ? asm_line : '0;
  assign d_rdata = (d_resp && !is_write_q) ? asm_line : '0;

endmodule

// File: tb/tb_bmem_arbiter.sv
// Self-checking bench for bmem_arbiter: table-driven single transactions,
// then hand-written reset-mid-read, round-robin and post-reset sequences.
module tb_bmem_arbiter;

  logic         clk, rst;
  logic [31:0]  i_addr, d_addr, bmem_addr, bmem_raddr;
  logic         i_read, i_resp, d_read, d_write, d_resp;
  logic [255:0] i_rdata, d_wdata, d_rdata;
  logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic [63:0]  bmem_wdata, bmem_rdata;

  typedef struct packed {
    logic         isD;
    logic         isWrite;
    logic [31:0]  addr;
    logic [255:0] line;
  } sbEntry_t;

  typedef struct {
    logic         isD;
    logic         isWrite;
    logic [31:0]  addr;
    logic [255:0] wline;
    logic [255:0] rline;
    int           readyLowBeat;
    int           strayBefore;
    int           expLatency;
  } vector_t;

  localparam int NV = 8;

  int       checks, errors;
  sbEntry_t sb[$];
  vector_t  vec[NV];
  int       readyLowBeat, strayBefore;

  logic         rdActive, strayDone, stallDone;
  int           rdIdx, wrIdx;
  logic [31:0]  rdAddr;
  logic [255:0] curLine;
  sbEntry_t     mEntry;

  bmem_arbiter #(.LINE_W(256), .BEAT_W(64)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] beatFor(input logic [31:0] a, input int k);
    if (a == 32'h1eceb000) return 64'(k + 1) * 64'h11;
    return {a, 24'ha5a5a5, 8'(k)};
  endfunction

  function automatic logic [255:0] lineFor(input logic [31:0] a);
    logic [255:0] l;
    l = '0;
    for (int k = 0; k < 4; k++) l[k*64 +: 64] = beatFor(a, k);
    return l;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vector_t v);
    sbEntry_t e;
    readyLowBeat = v.readyLowBeat;
    strayBefore  = v.strayBefore;
    e.isD     = v.isD;
    e.isWrite = v.isWrite;
    e.addr    = v.addr & ~32'h1f;
    e.line    = v.isWrite ? v.wline : v.rline;
    sb.push_back(e);
    d_wdata = v.wline;
    if (v.isD) begin
      d_addr  = v.addr;
      d_read  = !v.isWrite;
      d_write = v.isWrite;
    end else begin
      i_addr = v.addr;
      i_read = 1'b1;
    end
  endtask

  // Runs one request to its resp, scrambling the request fields after grant.
  task automatic runVector(input vector_t v, input string tag);
    int   cyc;
    logic got;
    applyStimulus(v);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        i_addr  = i_addr ^ 32'hffff_0000;
        d_addr  = d_addr ^ 32'hffff_0000;
        d_wdata = ~d_wdata;
      end
      if (v.isD ? d_resp : i_resp) got = 1'b1;
    end
    checkOutput({tag, "_latency"}, 256'(cyc), 256'(v.expLatency));
    if (!got) sb.delete();
    i_read  = 1'b0;
    d_read  = 1'b0;
    d_write = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_idle_after_resp"}, {bmem_read, bmem_write, i_resp, d_resp, bmem_addr}, '0);
    checkOutput({tag, "_rdata_cleared"}, i_rdata | d_rdata, '0);
  endtask

  // bmem model: returns four beats per read command, accepts write beats,
  // optionally injecting one stray beat or one ready-low cycle.
  initial begin
    bmem_ready = 1'b1; bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
    rdActive = 1'b0; strayDone = 1'b0; stallDone = 1'b0;
    rdIdx = 0; wrIdx = 0; rdAddr = '0; curLine = '0;
    forever begin
      @(negedge clk);
      bmem_ready = 1'b1; bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
      if (bmem_read) begin
        if (sb.size() == 0) checkOutput("rd_cmd_unexpected", 256'(bmem_read), '0);
        else checkOutput("rd_cmd_addr", bmem_addr, sb[0].addr);
        rdAddr = bmem_addr; rdIdx = 0; strayDone = 1'b0; rdActive = 1'b1;
      end else if (rdActive) begin
        bmem_rvalid = 1'b1;
        if (rdIdx == strayBefore && !strayDone) begin
          strayDone  = 1'b1;
          bmem_raddr = rdAddr ^ 32'h20;
          bmem_rdata = 64'hbad0_bad0_bad0_bad0;
        end else begin
          bmem_raddr = rdAddr;
          bmem_rdata = beatFor(rdAddr, rdIdx);
          rdIdx++;
          if (rdIdx == 4) rdActive = 1'b0;
        end
      end
      if (bmem_write) begin
        if (sb.size() == 0) checkOutput("wr_beat_unexpected", 256'(bmem_write), '0);
        else begin
          curLine = sb[0].line;
          checkOutput($sformatf("wr_addr_beat%0d", wrIdx), bmem_addr, sb[0].addr);
          checkOutput($sformatf("wr_data_beat%0d", wrIdx), bmem_wdata, curLine[wrIdx*64 +: 64]);
        end
        if (wrIdx == readyLowBeat && !stallDone) begin
          bmem_ready = 1'b0;
          stallDone  = 1'b1;
        end else begin
          wrIdx++;
          if (wrIdx == 4) begin
            wrIdx = 0;
            stallDone = 1'b0;
          end
        end
      end
    end
  end

  // Scoreboard monitor: every resp pops the oldest expected transaction.
  initial begin
    forever begin
      @(negedge clk);
      if (i_resp || d_resp) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_resp: got i_resp=%0b d_resp=%0b expected none", i_resp, d_resp);
        end else begin
          mEntry = sb.pop_front();
          checkOutput("resp_owner", 256'({i_resp, d_resp}), mEntry.isD ? 256'd1 : 256'd2);
          if (!mEntry.isWrite)
            checkOutput("resp_rdata", mEntry.isD ? d_rdata : i_rdata, mEntry.line);
          checkOutput("resp_other_rdata", mEntry.isD ? i_rdata : d_rdata, '0);
        end
      end
    end
  end

  initial begin
    int      cyc, nI, nD;
    vector_t vr;
    checks = 0; errors = 0;
    rst = 1'b1;
    i_addr = '0; i_read = 1'b0; d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    readyLowBeat = -1; strayBefore = -1;

    vec[0] = '{1'b0, 1'b0, 32'h1eceb004, '0,
               256'h0000000000000044_0000000000000033_0000000000000022_0000000000000011, -1, -1, 6};
    vec[1] = '{1'b1, 1'b1, 32'h00000100,
               256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111, '0, 1, -1, 6};
    vec[2] = '{1'b1, 1'b0, 32'h00000100, '0, lineFor(32'h00000100), -1, -1, 6};
    vec[3] = '{1'b0, 1'b0, 32'h80000a3c, '0, lineFor(32'h80000a20), -1, 2, 7};
    vec[4] = '{1'b1, 1'b1, 32'hdeadbee0,
               256'h0123456789abcdef_fedcba9876543210_a5a5a5a55a5a5a5a_0f0f0f0ff0f0f0f0, '0, -1, -1, 5};
    vec[5] = '{1'b1, 1'b1, 32'h00000040,
               256'hcafef00d00000003_cafef00d00000002_cafef00d00000001_cafef00d00000000, '0, 3, -1, 6};
    vec[6] = '{1'b1, 1'b0, 32'hffffffff, '0, lineFor(32'hffffffe0), -1, 0, 7};
    vec[7] = '{1'b0, 1'b0, 32'h00000020, '0, lineFor(32'h00000020), -1, -1, 6};

    repeat (3) @(negedge clk);
    checkOutput("reset_bus", {bmem_read, bmem_write, i_resp, d_resp, bmem_addr, bmem_wdata}, '0);
    checkOutput("reset_i_rdata", i_rdata, '0);
    checkOutput("reset_d_rdata", d_rdata, '0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < NV; v++) runVector(vec[v], $sformatf("vec%0d", v));

    // Reset after two read beats: the rest of the burst must be ignored.
    vr = '{1'b0, 1'b0, 32'h40000010, '0, lineFor(32'h40000000), -1, -1, 6};
    applyStimulus(vr);
    cyc = 0;
    while (!bmem_read && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("rst_cmd_seen", 256'(bmem_read), 256'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_read = 1'b0;
    sb.delete();
    checkOutput("rst_bus_zero", {bmem_read, bmem_write, i_resp, d_resp, bmem_addr, bmem_wdata}, '0);
    checkOutput("rst_rdata_zero", i_rdata | d_rdata, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_quiet%0d", k), {i_resp, d_resp, bmem_read, bmem_write}, '0);
    end

    // Both caches request twice: first tie after reset goes to dcache, then alternate.
    readyLowBeat = -1; strayBefore = -1;
    sb.push_back('{1'b1, 1'b0, 32'h00002000, lineFor(32'h00002000)});
    sb.push_back('{1'b0, 1'b0, 32'h00003000, lineFor(32'h00003000)});
    sb.push_back('{1'b1, 1'b0, 32'h00002040, lineFor(32'h00002040)});
    sb.push_back('{1'b0, 1'b0, 32'h00003040, lineFor(32'h00003040)});
    d_addr = 32'h00002000; i_addr = 32'h00003000;
    d_read = 1'b1; i_read = 1'b1;
    cyc = 0; nI = 0; nD = 0;
    while (nI + nD < 4 && cyc < 120) begin
      @(negedge clk);
      cyc++;
      if (d_resp) begin
        nD++;
        if (nD == 1) d_addr = 32'h00002040;
        else d_read = 1'b0;
      end
      if (i_resp) begin
        nI++;
        if (nI == 1) i_addr = 32'h00003040;
        else i_read = 1'b0;
      end
    end
    d_read = 1'b0; i_read = 1'b0;
    checkOutput("rr_total_cycles", 256'(cyc), 256'd27);
    checkOutput("rr_counts", {nD[7:0], nI[7:0]}, {8'd2, 8'd2});
    if (sb.size() != 0) sb.delete();
    @(negedge clk);

    vr = '{1'b0, 1'b0, 32'h00005550, '0, lineFor(32'h00005540), -1, -1, 6};
    runVector(vr, "post_reset_read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bmem_arbiter.md
# bmem_arbiter

Sits between the core's two line caches (instruction and data) and the single 64-bit burst memory port (bmem). It arbitrates the two caches' 256-bit line requests and runs one bmem transaction at a time. For reads it assembles four 64-bit return beats into a line. For writes it splits the line into four beats. The instruction-cache `dfp_*` port and the `cacheline_adapter` are replaced by this block.

## Interface
- `LINE_W`, 256: cache line width in bits.
- `BEAT_W`, 64: bmem beat width. `LINE_W/BEAT_W` = 4 beats.
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `i_addr`  in  32  icache line address.
- `i_read`  in  1  icache read request.
- `i_rdata`  out  256  icache line.
- `i_resp`  out  1  icache done pulse.
- `d_addr`  in  32  dcache line address.
- `d_read`  in  1  dcache read request.
- `d_write`  in  1  dcache write request.
- `d_wdata`  in  256  dcache writeback line.
- `d_rdata`  out  256  dcache line.
- `d_resp`  out  1  dcache done pulse.
- `bmem_addr`  out  32  burst address.
- `bmem_read`  out  1  read command.
- `bmem_write`  out  1  write beat valid.
- `bmem_wdata`  out  64  write beat.
- `bmem_ready`  in  1  bmem accepts a command or beat this cycle.
- `bmem_raddr`  in  32  address tag of the returning beat.
- `bmem_rdata`  in  64  returning beat.
- `bmem_rvalid`  in  1  return beat valid.

## Operation
- Clients hold `read`/`write` high until `resp`; `d_read` and `d_write` are never both high.
- Request fields are latched at grant. Later changes to them are ignored until `resp`.
- Single outstanding transaction. No overlap of reads and writes.
- FSM states:
  - IDLE: pick a winner. Latch addr, client id, r/w and wdata. Go to RD_ISSUE or WR_BURST.
  - RD_ISSUE: `bmem_read`=1 with the aligned addr. Hold until `bmem_ready`=1, then go to RD_WAIT.
  - RD_WAIT: capture a beat on `bmem_rvalid && bmem_raddr==latched aligned addr`; other beats are dropped. Beat k goes to line[64k+63:64k], k counted by a 2-bit counter. After beat 3, go to RESP.
  - WR_BURST: `bmem_write`=1, `bmem_wdata`=line beat k. k advances only on `bmem_ready`; if ready is low, the same beat is held. After beat 3 is accepted, go to RESP.
  - RESP: the granted client's `resp`=1 for exactly one cycle; for reads its `rdata` is valid in the same cycle. Then go to IDLE.
- `bmem_addr` = {latched_addr[31:5], 5'b0} whenever `bmem_read` or `bmem_write` is high, else 0.
- Arbitration when both caches request in IDLE:
  - Round-robin via a `last_was_d` flag, updated at every grant.
  - After reset, dcache wins the first tie.
  - With a single requester, that requester wins.
- `i_rdata`/`d_rdata` are driven from one line register. They are defined only during that client's `resp` cycle and are 0 otherwise.

## Timing
- Reset values:
  - FSM in IDLE; beat counter 0; `last_was_d`=0.
  - All outputs 0: `bmem_read`, `bmem_write`, `bmem_addr`, `bmem_wdata`, `i_resp`, `d_resp`, `i_rdata`, `d_rdata`.
- Grant is registered. A request first seen in IDLE at cycle t drives `bmem_read`/`bmem_write` at t+1.
- Read with `bmem_ready`=1: command at t+1. If the 4th matching beat arrives at cycle u, `resp` is at u+1.
- Write with `bmem_ready` high throughout: beats at t+1..t+4, `resp` at t+5. Each ready-low cycle adds one cycle.
- Reset mid-transaction: return to IDLE next cycle and drop the partial line. Beats arriving afterward are ignored because the FSM is not in RD_WAIT.
- A new request may be granted in the IDLE cycle right after RESP. This gives back-to-back transactions one cycle apart.
- `rvalid` outside RD_WAIT is ignored.

## Structure
- Package `rv32i_types`: add `arb_state_t` (IDLE, RD_ISSUE, RD_WAIT, WR_BURST, RESP) and `localparam BEATS_PER_LINE = 4`.
- One sub-module `line_assembler`: 4×64-bit shift/index register with a beat counter, shared by the read-capture path and the write-serialise path.

## Test plan
- `i_read` of 0x1eceb004 alone, beats 0x11/0x22/0x33/0x44 with raddr 0x1eceb000 -> `bmem_addr`=0x1eceb000, `i_rdata`=0x…44_…33_…22_…11, `i_resp` one cycle.
- `d_write` to 0x100 with ready low on the 2nd beat -> beats 0-3 emitted in order, beat 1 held 2 cycles, `d_resp` 6 cycles after grant.
- Simultaneous `i_read` and `d_read` held twice in a row -> order is d, i, d, i; each `resp` goes only to its owner.
- A stray `rvalid` beat with a mismatched raddr mid-read -> beat dropped, line still correct, `resp` delayed until the 4th matching beat.
- `rst` asserted after 2 read beats -> IDLE, outputs 0, the remaining 2 beats ignored, and the next request completes normally.
